// File: rtl/frame_fetch_pkg.sv
// Frame-fetch geometry constants and the router's frame-state encoding.
// Shared by the pixel-group router and its per-channel FIFOs.
package frame_fetch_pkg;

   localparam int FRAME_ROW_CNUM  = 30;
   localparam int CELL_ROW_PNUM   = 8;
   localparam int FRAME_COL_PGNUM = 10;
   localparam int FRAME_PGNUM     = FRAME_ROW_CNUM * CELL_ROW_PNUM * FRAME_COL_PGNUM;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUTE = 2'd1,
      ST_DROP  = 2'd2
   } rt_state_t;

endpackage

// File: rtl/pgroup_fifo.sv
// First-word fall-through FIFO with registered full/empty flags.
// Holds one channel's {last, pixel group} entries.
module pgroup_fifo #(
   parameter int W     = 257,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] wr_data,
   input  logic         pop,
   output logic [W-1:0] rd_data,
   output logic         full,
   output logic         empty
);
   import frame_fetch_pkg::*;

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count, count_nxt;
   logic          do_push, do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      if (do_push && !do_pop)
         count_nxt = count + (AW+1)'(1);
      else if (do_pop && !do_push)
         count_nxt = count - (AW+1)'(1);
   end

   // Flags come from the next count so they are registered yet exact.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count_nxt;
         full  <= (count_nxt == (AW+1)'(DEPTH));
         empty <= (count_nxt == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/axis_pgroup_router.sv
// Routes AXI-Stream pixel-group frames to per-processor channel FIFOs,
// locking each frame to one channel and checking frame length.
module axis_pgroup_router #(
   parameter int IP_AMT      = 4,
   parameter int DATA_W      = 256,
   parameter int TDEST_W     = (IP_AMT > 1) ? $clog2(IP_AMT) : 1,
   parameter int FIFO_DEPTH  = 4,
   parameter int FRAME_PGNUM = frame_fetch_pkg::FRAME_PGNUM,
   parameter int PGCNT_W     = $clog2(FRAME_PGNUM)
) (
   input  logic                     s_aclk,
   input  logic                     s_aresetn,
   input  logic                     mode_i,
   input  logic [TDEST_W-1:0]       s_tdest_i,
   input  logic [DATA_W-1:0]        s_tdata_i,
   input  logic                     s_tlast_i,
   input  logic                     s_tvalid_i,
   output logic                     s_tready_o,
   output logic [IP_AMT*DATA_W-1:0] pgroup_o,
   output logic [IP_AMT-1:0]        pgroup_valid_o,
   input  logic [IP_AMT-1:0]        pgroup_ready_i,
   output logic [IP_AMT-1:0]        frame_done_o,
   output logic                     frame_err_o
);
   import frame_fetch_pkg::*;

   rt_state_t          state_q, state_d;
   logic [TDEST_W-1:0] dest_q, dest_d, rr_ptr_q, rr_ptr_d, cur_dest;
   logic               mode_q, mode_d, cur_mode;
   logic [PGCNT_W-1:0] pg_cnt_q, pg_cnt_d;
   logic               dest_err, drop_now, tgt_full, accept;
   logic               cnt_end, frame_end, len_err;
   logic [DATA_W:0]    push_word;
   logic [IP_AMT-1:0]  fifo_full, fifo_empty, push, pop;
   logic [DATA_W:0]    fifo_rd [IP_AMT];

   // In IDLE the beat on the bus decides the channel; afterwards the lock holds.
   always_comb begin
      cur_dest = dest_q;
      cur_mode = mode_q;
      dest_err = 1'b0;
      if (state_q == ST_IDLE) begin
         cur_mode = mode_i;
         cur_dest = mode_i ? rr_ptr_q : s_tdest_i;
         dest_err = !mode_i && (32'(s_tdest_i) >= IP_AMT);
      end
      drop_now = (state_q == ST_DROP) || dest_err;
      tgt_full = 1'b0;
      for (int ch = 0; ch < IP_AMT; ch++)
         if (cur_dest == TDEST_W'(ch)) tgt_full = fifo_full[ch];
      s_tready_o  = s_aresetn && (drop_now || !tgt_full);
      accept      = s_tvalid_i && s_tready_o;
      cnt_end     = (pg_cnt_q == PGCNT_W'(FRAME_PGNUM - 1));
      frame_end   = s_tlast_i || cnt_end;
      len_err     = s_tlast_i ^ cnt_end;
      frame_err_o = accept && (dest_err || len_err);
      push_word   = {frame_end, s_tdata_i};
      for (int ch = 0; ch < IP_AMT; ch++)
         push[ch] = accept && !drop_now && (cur_dest == TDEST_W'(ch));
   end

   always_comb begin
      state_d  = state_q;
      dest_d   = dest_q;
      mode_d   = mode_q;
      pg_cnt_d = pg_cnt_q;
      rr_ptr_d = rr_ptr_q;
      if (accept) begin
         if (state_q == ST_IDLE) begin
            dest_d = cur_dest;
            mode_d = cur_mode;
         end
         if (frame_end) begin
            state_d  = ST_IDLE;
            pg_cnt_d = '0;
            if (!drop_now && cur_mode)
               rr_ptr_d = (rr_ptr_q == TDEST_W'(IP_AMT - 1)) ? '0 : rr_ptr_q + TDEST_W'(1);
         end else begin
            pg_cnt_d = pg_cnt_q + PGCNT_W'(1);
            if (state_q == ST_IDLE)
               state_d = drop_now ? ST_DROP : ST_ROUTE;
         end
      end
   end

   always_ff @(posedge s_aclk or negedge s_aresetn) begin
      if (!s_aresetn) begin
         state_q  <= ST_IDLE;
         dest_q   <= '0;
         mode_q   <= 1'b0;
         pg_cnt_q <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         dest_q   <= dest_d;
         mode_q   <= mode_d;
         pg_cnt_q <= pg_cnt_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   // Output data is zeroed while a channel is empty so the bus is quiet.
   for (genvar ch = 0; ch < IP_AMT; ch++) begin : g_ch
      pgroup_fifo #(
         .W     (DATA_W + 1),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk     (s_aclk),
         .rst_n   (s_aresetn),
         .push    (push[ch]),
         .wr_data (push_word),
         .pop     (pop[ch]),
         .rd_data (fifo_rd[ch]),
         .full    (fifo_full[ch]),
         .empty   (fifo_empty[ch])
      );
      assign pgroup_valid_o[ch] = !fifo_empty[ch];
      assign pop[ch]            = !fifo_empty[ch] && pgroup_ready_i[ch];
      assign frame_done_o[ch]   = pop[ch] && fifo_rd[ch][DATA_W];
      assign pgroup_o[(ch+1)*DATA_W-1 -: DATA_W] =
         fifo_empty[ch] ? '0 : fifo_rd[ch][DATA_W-1:0];
   end

endmodule

// File: tb/tb_axis_pgroup_router.sv
// Directed bench for axis_pgroup_router: routing modes, back-pressure,
// length errors, bad destinations and mid-frame reset.
module tb_axis_pgroup_router;

   localparam int IP_AMT      = 4;
   localparam int DATA_W      = 256;
   localparam int TDEST_W     = 3;
   localparam int FIFO_DEPTH  = 4;
   localparam int FRAME_PGNUM = 2400;
   localparam int PGCNT_W     = 12;

   logic                     s_aclk = 1'b0;
   logic                     s_aresetn = 1'b0;
   logic                     mode_i = 1'b0;
   logic [TDEST_W-1:0]       s_tdest_i = '0;
   logic [DATA_W-1:0]        s_tdata_i = '0;
   logic                     s_tlast_i = 1'b0;
   logic                     s_tvalid_i = 1'b0;
   logic                     s_tready_o;
   logic [IP_AMT*DATA_W-1:0] pgroup_o;
   logic [IP_AMT-1:0]        pgroup_valid_o;
   logic [IP_AMT-1:0]        pgroup_ready_i = '1;
   logic [IP_AMT-1:0]        frame_done_o;
   logic                     frame_err_o;

   axis_pgroup_router #(
      .IP_AMT      (IP_AMT),
      .DATA_W      (DATA_W),
      .TDEST_W     (TDEST_W),
      .FIFO_DEPTH  (FIFO_DEPTH),
      .FRAME_PGNUM (FRAME_PGNUM),
      .PGCNT_W     (PGCNT_W)
   ) dut (
      .s_aclk         (s_aclk),
      .s_aresetn      (s_aresetn),
      .mode_i         (mode_i),
      .s_tdest_i      (s_tdest_i),
      .s_tdata_i      (s_tdata_i),
      .s_tlast_i      (s_tlast_i),
      .s_tvalid_i     (s_tvalid_i),
      .s_tready_o     (s_tready_o),
      .pgroup_o       (pgroup_o),
      .pgroup_valid_o (pgroup_valid_o),
      .pgroup_ready_i (pgroup_ready_i),
      .frame_done_o   (frame_done_o),
      .frame_err_o    (frame_err_o)
   );

   always #5 s_aclk = ~s_aclk;

   typedef struct packed {
      logic [1:0]        ch;
      logic              done;
      logic [DATA_W-1:0] data;
   } rec_t;

   rec_t rx_q[$];
   int   tests = 0, fails = 0;
   int   err_cnt = 0, valid_seen = 0, orphan_done = 0, acc_cnt = 0, stall_cnt = 0;
   int   err0, stall0, acc0, vs0;
   bit   abort_send = 1'b0;

   function automatic logic [DATA_W-1:0] pat(input int tag, input int idx);
      logic [31:0] w;
      w = {tag[15:0], idx[15:0]};
      return {8{w}};
   endfunction

   function automatic int count_ch(input int ch);
      int n = 0;
      foreach (rx_q[i]) if (rx_q[i].ch == 2'(ch)) n++;
      return n;
   endfunction

   // Entries seen on ch must be beats base..base+n-1 of tag, done only on the last.
   function automatic int seq_bad(input int ch, input int tag, input int base, input int n);
      int k = 0, bad = 0;
      foreach (rx_q[i]) begin
         if (rx_q[i].ch == 2'(ch)) begin
            if (k >= n) bad++;
            else if (rx_q[i].data !== pat(tag, base + k) || rx_q[i].done !== (k == n - 1)) bad++;
            k++;
         end
      end
      return bad;
   endfunction

   // Pops are recorded at the negedge before the edge that performs them.
   always @(negedge s_aclk) begin
      if (frame_err_o) err_cnt++;
      if (|pgroup_valid_o) valid_seen++;
      for (int ch = 0; ch < IP_AMT; ch++) begin
         if (pgroup_valid_o[ch] && pgroup_ready_i[ch])
            rx_q.push_back(rec_t'{ch: 2'(ch), done: frame_done_o[ch], data: pgroup_o[ch*DATA_W +: DATA_W]});
         else if (frame_done_o[ch])
            orphan_done++;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge s_aclk);
      #1;
   endtask

   task automatic begin_test();
      idle(2);
      rx_q.delete();
      err0 = err_cnt; stall0 = stall_cnt; acc0 = acc_cnt; vs0 = valid_seen;
   endtask

   task automatic send_frame(input logic md, input logic [TDEST_W-1:0] d0, input logic [TDEST_W-1:0] d1,
                             input int tag, input int n, input int last_at);
      int waited;
      for (int k = 0; k < n; k++) begin
         if (abort_send) break;
         mode_i     = (k == 0) ? md : ~md;
         s_tdest_i  = (k == 0) ? d0 : d1;
         s_tdata_i  = pat(tag, k);
         s_tlast_i  = (k == last_at);
         s_tvalid_i = 1'b1;
         waited = 0;
         @(negedge s_aclk);
         while (!s_tready_o && !abort_send && waited < 200) begin
            stall_cnt++;
            waited++;
            @(negedge s_aclk);
         end
         if (abort_send) break;
         if (!s_tready_o) begin
            tests++; fails++;
            $display("FAIL send_beat tag=%0d beat=%0d: s_tready_o=%0b after 200 cycles, required 1", tag, k, s_tready_o);
            break;
         end
         @(posedge s_aclk);
         #1;
         acc_cnt++;
      end
      s_tvalid_i = 1'b0;
      s_tlast_i  = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge s_aclk);
      tests++; if (s_tready_o !== 1'b0) begin fails++; $display("FAIL rst_tready: got %0b want 0", s_tready_o); end
      tests++; if (pgroup_valid_o !== '0) begin fails++; $display("FAIL rst_valid: got %b want 0000", pgroup_valid_o); end
      tests++; if (pgroup_o !== '0) begin fails++; $display("FAIL rst_pgroup: got nonzero want 0"); end
      tests++; if (frame_done_o !== '0) begin fails++; $display("FAIL rst_done: got %b want 0000", frame_done_o); end
      tests++; if (frame_err_o !== 1'b0) begin fails++; $display("FAIL rst_err: got %0b want 0", frame_err_o); end
      @(posedge s_aclk); #1;
      s_aresetn = 1'b1;
      @(negedge s_aclk);
      tests++; if (s_tready_o !== 1'b1) begin fails++; $display("FAIL post_rst_tready: got %0b want 1", s_tready_o); end
      tests++; if (pgroup_valid_o !== '0) begin fails++; $display("FAIL post_rst_valid: got %b want 0000", pgroup_valid_o); end
   endtask

   task automatic test_route_tdest();
      begin_test();
      send_frame(1'b0, 3'd2, 3'd1, 1, FRAME_PGNUM, FRAME_PGNUM - 1);
      idle(8);
      tests++; if (count_ch(2) !== FRAME_PGNUM) begin fails++; $display("FAIL td_count: got %0d want %0d", count_ch(2), FRAME_PGNUM); end
      tests++; if (seq_bad(2, 1, 0, FRAME_PGNUM) !== 0) begin fails++; $display("FAIL td_order: got %0d bad entries want 0", seq_bad(2, 1, 0, FRAME_PGNUM)); end
      tests++; if (rx_q.size() !== FRAME_PGNUM) begin fails++; $display("FAIL td_other_ch: got %0d total pops want %0d", rx_q.size(), FRAME_PGNUM); end
      tests++; if (err_cnt - err0 !== 0) begin fails++; $display("FAIL td_err: got %0d pulses want 0", err_cnt - err0); end
      tests++; if (stall_cnt - stall0 !== 0) begin fails++; $display("FAIL td_throughput: got %0d stalls want 0", stall_cnt - stall0); end
   endtask

   task automatic test_round_robin();
      begin_test();
      send_frame(1'b1, 3'd3, 3'd3, 2, FRAME_PGNUM, FRAME_PGNUM - 1);
      send_frame(1'b1, 3'd3, 3'd3, 3, FRAME_PGNUM, FRAME_PGNUM - 1);
      send_frame(1'b1, 3'd3, 3'd3, 4, FRAME_PGNUM, FRAME_PGNUM - 1);
      send_frame(1'b1, 3'd0, 3'd0, 6, 1, 0);
      idle(8);
      for (int ch = 0; ch < 3; ch++) begin
         tests++; if (count_ch(ch) !== FRAME_PGNUM) begin fails++; $display("FAIL rr_count ch%0d: got %0d want %0d", ch, count_ch(ch), FRAME_PGNUM); end
         tests++; if (seq_bad(ch, ch + 2, 0, FRAME_PGNUM) !== 0) begin fails++; $display("FAIL rr_order ch%0d: got %0d bad want 0", ch, seq_bad(ch, ch + 2, 0, FRAME_PGNUM)); end
      end
      tests++; if (count_ch(3) !== 1) begin fails++; $display("FAIL rr_ptr3 count: got %0d want 1", count_ch(3)); end
      tests++; if (seq_bad(3, 6, 0, 1) !== 0) begin fails++; $display("FAIL rr_ptr3 data: got %0d bad want 0", seq_bad(3, 6, 0, 1)); end
      tests++; if (err_cnt - err0 !== 1) begin fails++; $display("FAIL rr_err: got %0d pulses want 1", err_cnt - err0); end
   endtask

   task automatic test_backpressure();
      int n;
      begin_test();
      pgroup_ready_i = 4'b1101;
      fork
         send_frame(1'b0, 3'd1, 3'd0, 5, 10, 9);
      join_none
      idle(12);
      @(negedge s_aclk);
      tests++; if (s_tready_o !== 1'b0) begin fails++; $display("FAIL bp_tready: got %0b want 0", s_tready_o); end
      tests++; if (acc_cnt - acc0 !== FIFO_DEPTH) begin fails++; $display("FAIL bp_accepted: got %0d want %0d", acc_cnt - acc0, FIFO_DEPTH); end
      tests++; if (pgroup_valid_o[1] !== 1'b1) begin fails++; $display("FAIL bp_valid: got %0b want 1", pgroup_valid_o[1]); end
      tests++; if (pgroup_o[2*DATA_W-1 -: DATA_W] !== pat(5, 0)) begin fails++; $display("FAIL bp_head: got %h want %h", pgroup_o[2*DATA_W-1 -: DATA_W], pat(5, 0)); end
      @(negedge s_aclk);
      tests++; if (pgroup_o[2*DATA_W-1 -: DATA_W] !== pat(5, 0)) begin fails++; $display("FAIL bp_stable: got %h want %h", pgroup_o[2*DATA_W-1 -: DATA_W], pat(5, 0)); end
      @(posedge s_aclk); #1;
      pgroup_ready_i = '1;
      n = 0;
      while (acc_cnt - acc0 < 10 && n < 100) begin @(posedge s_aclk); n++; end
      tests++; if (acc_cnt - acc0 !== 10) begin fails++; $display("FAIL bp_resume: got %0d accepted want 10", acc_cnt - acc0); end
      idle(8);
      tests++; if (count_ch(1) !== 10) begin fails++; $display("FAIL bp_count: got %0d want 10", count_ch(1)); end
      tests++; if (seq_bad(1, 5, 0, 10) !== 0) begin fails++; $display("FAIL bp_order: got %0d bad want 0", seq_bad(1, 5, 0, 10)); end
      tests++; if (rx_q.size() !== 10) begin fails++; $display("FAIL bp_total: got %0d want 10", rx_q.size()); end
      tests++; if (err_cnt - err0 !== 1) begin fails++; $display("FAIL bp_err: got %0d want 1", err_cnt - err0); end
   endtask

   task automatic test_short_frame();
      int err_mid;
      begin_test();
      send_frame(1'b0, 3'd3, 3'd0, 7, 100, 99);
      err_mid = err_cnt - err0;
      send_frame(1'b0, 3'd0, 3'd0, 8, 1, 0);
      idle(8);
      tests++; if (err_mid !== 1) begin fails++; $display("FAIL sf_err: got %0d pulses want 1", err_mid); end
      tests++; if (count_ch(3) !== 100) begin fails++; $display("FAIL sf_count: got %0d want 100", count_ch(3)); end
      tests++; if (seq_bad(3, 7, 0, 100) !== 0) begin fails++; $display("FAIL sf_order_done: got %0d bad want 0", seq_bad(3, 7, 0, 100)); end
      tests++; if (count_ch(0) !== 1) begin fails++; $display("FAIL sf_next_count: got %0d want 1", count_ch(0)); end
      tests++; if (seq_bad(0, 8, 0, 1) !== 0) begin fails++; $display("FAIL sf_next_data: got %0d bad want 0", seq_bad(0, 8, 0, 1)); end
      tests++; if (err_cnt - err0 !== 2) begin fails++; $display("FAIL sf_err_total: got %0d want 2", err_cnt - err0); end
   endtask

   task automatic test_long_frame();
      begin_test();
      send_frame(1'b0, 3'd2, 3'd0, 9, FRAME_PGNUM + 1, FRAME_PGNUM);
      idle(8);
      tests++; if (count_ch(2) !== FRAME_PGNUM) begin fails++; $display("FAIL lf_count: got %0d want %0d", count_ch(2), FRAME_PGNUM); end
      tests++; if (seq_bad(2, 9, 0, FRAME_PGNUM) !== 0) begin fails++; $display("FAIL lf_order_done: got %0d bad want 0", seq_bad(2, 9, 0, FRAME_PGNUM)); end
      tests++; if (count_ch(0) !== 1) begin fails++; $display("FAIL lf_spill_count: got %0d want 1", count_ch(0)); end
      tests++; if (seq_bad(0, 9, FRAME_PGNUM, 1) !== 0) begin fails++; $display("FAIL lf_spill_data: got %0d bad want 0", seq_bad(0, 9, FRAME_PGNUM, 1)); end
      tests++; if (err_cnt - err0 !== 2) begin fails++; $display("FAIL lf_err: got %0d want 2", err_cnt - err0); end
   endtask

   task automatic test_bad_dest();
      begin_test();
      send_frame(1'b0, 3'd5, 3'd5, 10, FRAME_PGNUM, FRAME_PGNUM - 1);
      idle(8);
      tests++; if (err_cnt - err0 !== 1) begin fails++; $display("FAIL bd_err: got %0d want 1", err_cnt - err0); end
      tests++; if (stall_cnt - stall0 !== 0) begin fails++; $display("FAIL bd_tready: got %0d stalls want 0", stall_cnt - stall0); end
      tests++; if (acc_cnt - acc0 !== FRAME_PGNUM) begin fails++; $display("FAIL bd_accepted: got %0d want %0d", acc_cnt - acc0, FRAME_PGNUM); end
      tests++; if (valid_seen - vs0 !== 0) begin fails++; $display("FAIL bd_valid: got %0d valid cycles want 0", valid_seen - vs0); end
   endtask

   task automatic test_reset_mid_frame();
      begin_test();
      send_frame(1'b1, 3'd0, 3'd0, 11, 1, 0);
      idle(6);
      tests++; if (count_ch(1) !== 1) begin fails++; $display("FAIL rm_pre_rr: got %0d on ch1 want 1", count_ch(1)); end
      pgroup_ready_i = 4'b1011;
      fork
         send_frame(1'b0, 3'd2, 3'd2, 12, FRAME_PGNUM, FRAME_PGNUM - 1);
      join_none
      idle(3);
      tests++; if (pgroup_valid_o[2] !== 1'b1) begin fails++; $display("FAIL rm_pre_valid: got %0b want 1", pgroup_valid_o[2]); end
      #2;
      abort_send = 1'b1;
      s_aresetn  = 1'b0;
      #1;
      tests++; if (s_tready_o !== 1'b0) begin fails++; $display("FAIL rm_tready: got %0b want 0", s_tready_o); end
      tests++; if (pgroup_valid_o !== '0) begin fails++; $display("FAIL rm_valid: got %b want 0000", pgroup_valid_o); end
      tests++; if (pgroup_o !== '0) begin fails++; $display("FAIL rm_pgroup: got nonzero want 0"); end
      tests++; if (frame_done_o !== '0 || frame_err_o !== 1'b0) begin fails++; $display("FAIL rm_pulses: got done=%b err=%0b want 0", frame_done_o, frame_err_o); end
      idle(3);
      s_aresetn = 1'b1;
      abort_send = 1'b0;
      pgroup_ready_i = '1;
      begin_test();
      idle(4);
      tests++; if (valid_seen - vs0 !== 0 || err_cnt - err0 !== 0) begin fails++; $display("FAIL rm_lost: got valid=%0d err=%0d want 0 0", valid_seen - vs0, err_cnt - err0); end
      send_frame(1'b1, 3'd3, 3'd0, 13, 1, 0);
      send_frame(1'b0, 3'd3, 3'd0, 14, 3, 2);
      idle(8);
      tests++; if (count_ch(0) !== 1 || seq_bad(0, 13, 0, 1) !== 0) begin fails++; $display("FAIL rm_rr_restart: got %0d on ch0 want 1", count_ch(0)); end
      tests++; if (count_ch(3) !== 3 || seq_bad(3, 14, 0, 3) !== 0) begin fails++; $display("FAIL rm_next_frame: got %0d on ch3 want 3", count_ch(3)); end
      tests++; if (rx_q.size() !== 4) begin fails++; $display("FAIL rm_total: got %0d want 4", rx_q.size()); end
   endtask

   task automatic test_done_sanity();
      tests++; if (orphan_done !== 0) begin fails++; $display("FAIL done_without_pop: got %0d want 0", orphan_done); end
   endtask

   initial begin
      test_reset();
      test_route_tdest();
      test_round_robin();
      test_backpressure();
      test_short_frame();
      test_long_frame();
      test_bad_dest();
      test_reset_mid_frame();
      test_done_sanity();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
